palindrome_tx: RTL and testbench

Serial palindrome frame transmitter: it is the stream source for the 3-bit palindrome detector. It accepts a W-bit payload over a valid/ready handshake and emits one bit per cycle as a palindromic frame: the payload MSB-first, then its mirror. It drives the serial-bit stimulus into the detector path, and optionally self-checks its own output stream.

---
 rtl/palindrome_tx_if.sv | 11 +
 rtl/palindrome_tx.sv | 140 ++++++++++++++
 tb/tb_palindrome_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/palindrome_tx_if.sv
// Payload handshake bundle for palindrome_tx: W-bit payload with valid/ready.
interface palindrome_tx_if #(
  parameter int unsigned W = 4
) ();
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/palindrome_tx.sv
// Serial palindrome frame transmitter: payload MSB-first, then its mirror, one bit per cycle.
// Optional output-stream self-check monitor enabled by `define PALINDROME_TX_SELFCHECK_EN.
module palindrome_tx #(
  parameter int unsigned W   = 4,
  parameter bit          ODD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  palindrome_tx_if.slave  in_if,
  output logic            x_o,
  output logic            bit_valid_o,
  output logic            sof_o,
  output logic            eof_o,
  output logic [7:0]      pal_cnt_o
);

  localparam int unsigned IdxW = $clog2(W);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(W - 1);

  typedef enum logic [1:0] {StIdle, StFwd, StRev} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    hold_q, hold_d;
  logic            x_q, x_d;
  logic            bit_valid_q, bit_valid_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            ready;
  logic            hs;

  // The eof cycle doubles as an accept slot so frames chain without a gap.
  assign ready       = (state_q == StIdle) || eof_q;
  assign in_if.ready_o = ready;
  assign hs          = in_if.valid_i && ready;

  // state_d/idx_d describe the bit that will be on x_o in the next cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: ;
      StFwd: begin
        if (idx_q == '0) begin
          state_d = StRev;
          idx_d   = IdxW'(ODD);
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StRev: begin
        if (idx_q == IdxMax) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (hs) begin
      state_d = StFwd;
      idx_d   = IdxMax;
      hold_d  = in_if.data_i;
    end
    bit_valid_d = (state_d != StIdle);
    sof_d       = hs;
    eof_d       = (state_d == StRev) && (idx_d == IdxMax);
    x_d         = bit_valid_d ? hold_d[idx_d] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      hold_q      <= '0;
      x_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      x_q         <= x_d;
      bit_valid_q <= bit_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  assign x_o         = x_q;
  assign bit_valid_o = bit_valid_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;

`ifdef PALINDROME_TX_SELFCHECK_EN
  logic       h1_q, h1_d;
  logic       h2_q, h2_d;
  logic [1:0] nv_q, nv_d;
  logic [7:0] cnt_q, cnt_d;

  // Window spans frames and idle gaps; only valid bits shift it.
  always_comb begin
    h1_d  = h1_q;
    h2_d  = h2_q;
    nv_d  = nv_q;
    cnt_d = cnt_q;
    if (bit_valid_q) begin
      if ((nv_q == 2'd2) && (x_q == h2_q) && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'd1;
      end
      h2_d = h1_q;
      h1_d = x_q;
      if (nv_q != 2'd2) begin
        nv_d = nv_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1_q  <= 1'b0;
      h2_q  <= 1'b0;
      nv_q  <= 2'd0;
      cnt_q <= 8'd0;
    end else begin
      h1_q  <= h1_d;
      h2_q  <= h2_d;
      nv_q  <= nv_d;
      cnt_q <= cnt_d;
    end
  end

  assign pal_cnt_o = cnt_q;
`else
  assign pal_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_palindrome_tx.sv
// Bench for palindrome_tx: three instances (W=3 even, W=3 odd, W=4 even) checked every cycle
// against a frame-level model, plus literal frame/count expectations.
module tb_palindrome_tx;

`ifdef PALINDROME_TX_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  palindrome_tx_if #(.W(3)) if0 ();
  palindrome_tx_if #(.W(3)) if1 ();
  palindrome_tx_if #(.W(4)) if2 ();

  logic [3:0] din [3];
  logic [2:0] vld;
  logic [2:0] xv, bvv, sofv, eofv, rdyv;
  logic [7:0] pal0, pal1, pal2;
  logic [7:0] pal [3];

  assign if0.data_i  = din[0][2:0];
  assign if1.data_i  = din[1][2:0];
  assign if2.data_i  = din[2];
  assign if0.valid_i = vld[0];
  assign if1.valid_i = vld[1];
  assign if2.valid_i = vld[2];
  assign rdyv        = {if2.ready_o, if1.ready_o, if0.ready_o};
  assign pal[0]      = pal0;
  assign pal[1]      = pal1;
  assign pal[2]      = pal2;

  palindrome_tx #(.W(3), .ODD(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_if(if0), .x_o(xv[0]), .bit_valid_o(bvv[0]),
    .sof_o(sofv[0]), .eof_o(eofv[0]), .pal_cnt_o(pal0)
  );
  palindrome_tx #(.W(3), .ODD(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_if(if1), .x_o(xv[1]), .bit_valid_o(bvv[1]),
    .sof_o(sofv[1]), .eof_o(eofv[1]), .pal_cnt_o(pal1)
  );
  palindrome_tx #(.W(4), .ODD(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .in_if(if2), .x_o(xv[2]), .bit_valid_o(bvv[2]),
    .sof_o(sofv[2]), .eof_o(eofv[2]), .pal_cnt_o(pal2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: each accepted payload becomes a list of frame bits played out one per cycle.
  int  mw [3] = '{3, 3, 4};
  int  mo [3] = '{0, 1, 0};
  bit  fb [3][32];
  int  flen [3];
  int  fpos [3];
  bit  act [3];
  int  mpal [3];
  bit  p1 [3];
  bit  p2 [3];
  int  npv [3];
  logic [15:0] cap [3];

  function automatic bit m_ready(int k);
    return !act[k] || (fpos[k] == flen[k] - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        act[k] = 1'b0; fpos[k] = 0; flen[k] = 0;
        mpal[k] = 0; p1[k] = 1'b0; p2[k] = 1'b0; npv[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit rdy;
        rdy = m_ready(k);
        if (act[k]) begin
          bit cur;
          cur = fb[k][fpos[k]];
          if (npv[k] >= 2 && cur == p2[k] && mpal[k] < 255) mpal[k]++;
          p2[k] = p1[k];
          p1[k] = cur;
          npv[k]++;
        end
        if (act[k] && fpos[k] < flen[k] - 1) begin
          fpos[k]++;
        end else begin
          act[k] = 1'b0;
          if (vld[k] && rdy) begin
            int n;
            n = 0;
            for (int i = mw[k] - 1; i >= 0; i--) begin
              fb[k][n] = din[k][i];
              n++;
            end
            for (int i = mo[k]; i < mw[k]; i++) begin
              fb[k][n] = din[k][i];
              n++;
            end
            flen[k] = n;
            fpos[k] = 0;
            act[k]  = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [4:0] exp_v, got_v;
      exp_v = {m_ready(k), act[k], act[k] && fpos[k] == 0,
               act[k] && fpos[k] == flen[k] - 1, act[k] ? fb[k][fpos[k]] : 1'b0};
      got_v = {rdyv[k], bvv[k], sofv[k], eofv[k], xv[k]};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_dut%0d t=%0t: rdy/bv/sof/eof/x got %b required %b",
                 k, $time, got_v, exp_v);
      end
      if (bvv[k] === 1'b1) cap[k] = {cap[k][14:0], xv[k]};
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      din[k] = 4'd0;
      cap[k] = 16'd0;
    end
    vld   = 3'b000;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (5) @(posedge clk);

    // W=3 even, payload 110
    #2 din[0] = 4'b0110; vld[0] = 1'b1;
    @(posedge clk); #2 vld[0] = 1'b0;
    repeat (8) @(posedge clk); #2;
    check("even3_frame", int'(cap[0][5:0]), int'(6'b110011));
    check("even3_pal", int'(pal[0]), 0);

    // W=3 odd, payload 110
    din[1] = 4'b0110; vld[1] = 1'b1;
    @(posedge clk); #2 vld[1] = 1'b0;
    repeat (8) @(posedge clk); #2;
    check("odd3_frame", int'(cap[1][4:0]), int'(5'b11011));
    check("odd3_pal", int'(pal[1]), SC ? 1 : 0);

    // W=4 even, A then 3 with valid held high
    din[2] = 4'hA; vld[2] = 1'b1;
    @(posedge clk); #2 din[2] = 4'h3;
    begin
      int i;
      for (i = 0; i < 20 && rdyv[2] !== 1'b1; i++) begin
        @(posedge clk); #2;
      end
      if (rdyv[2] !== 1'b1) begin
        n_cmp++; n_fail++;
        $display("FAIL chain_wait: got ready=%b required 1 within 20 cycles", rdyv[2]);
      end
    end
    @(posedge clk); #2 vld[2] = 1'b0;
    repeat (12) @(posedge clk); #2;
    check("chain_frames", int'(cap[2]), int'(16'hA53C));
    check("chain_pal", int'(pal[2]), SC ? 7 : 0);

    // Payload toggled while ready is low must not leak into the frame
    din[2] = 4'hC; vld[2] = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 6; i++) begin
      vld[2] = 1'b1;
      din[2] = 4'($urandom);
      @(posedge clk); #2;
    end
    vld[2] = 1'b0;
    repeat (10) @(posedge clk); #2;
    check("toggle_frame", int'(cap[2][7:0]), int'(8'b11000011));
    check("toggle_pal", int'(pal[2]), int'(SC ? mpal[2] : 0));

    // Reset during third bit of a frame
    din[0] = 4'b0101; vld[0] = 1'b1;
    @(posedge clk); #2 vld[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("rst_async_outs", int'({bvv[0], sofv[0], eofv[0], xv[0]}), 0);
    check("rst_async_pal0", int'(pal[0]), 0);
    check("rst_async_pal2", int'(pal[2]), 0);
    @(posedge clk);
    @(posedge clk); #2 reset = 1'b1;
    repeat (10) @(posedge clk); #2;
    check("post_rst_idle_bv", int'(bvv), 0);
    check("post_rst_ready", int'(rdyv), 7);
    check("post_rst_pal0", int'(pal[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
